// File: rtl/cflog_pkg.sv
// Shared definitions for the control-flow log pointer controller.
package cflog_pkg;

  // Controller state: RUN writes entries, FULL waits for the log to be consumed.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // One log entry is {src, dest}, i.e. two 16-bit words.
  localparam logic [15:0] ENTRY_WORDS = 16'd2;

endpackage

// File: rtl/cflog_evt_fifo.sv
// Small event buffer holding {src, dest} pairs; DEPTH must be a power of two >= 2.
module cflog_evt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  // Read/write pointers; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cflog_ptr_ctrl.sv
// Buffers control-flow events and writes them as 2-word entries into cflogmem,
// stopping when the log is full until the consumer acknowledges a flush.
module cflog_ptr_ctrl
  import cflog_pkg::*;
#(
  parameter logic [15:0] CFLOW_LOGS_SIZE = 16'h0100,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        evt_valid,
  input  logic [15:0] evt_src,
  input  logic [15:0] evt_dest,
  output logic        evt_ready,
  input  logic        spec_hold,
  input  logic        flush_ack,
  output logic [15:0] cflow_logs_ptr_din,
  output logic [15:0] cflow_src,
  output logic [15:0] cflow_dest,
  output logic        cflow_hw_wen,
  output logic        flush_req,
  output logic        ovf
);

  state_t      state;
  logic [15:0] ptr;
  logic [16:0] ptr_nxt;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] head;
  logic        push;
  logic        pop;

  // 17-bit sum so the room check cannot be fooled by 16-bit wrap.
  assign ptr_nxt   = {1'b0, ptr} + {1'b0, ENTRY_WORDS};
  assign evt_ready = ~fifo_full;
  assign push      = evt_valid & ~fifo_full;
  assign pop       = (state == ST_RUN) & ~fifo_empty & ~spec_hold &
                     (ptr_nxt <= {1'b0, CFLOW_LOGS_SIZE});

  assign cflow_hw_wen       = pop;
  assign cflow_src          = pop ? head[31:16] : '0;
  assign cflow_dest         = pop ? head[15:0]  : '0;
  assign cflow_logs_ptr_din = pop ? ptr_nxt[15:0] : ptr;
  assign flush_req          = (state == ST_FULL);

  cflog_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (mclk),
    .rst_n (puc_rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({evt_src, evt_dest}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State and pointer: advance on each write, park in FULL once the log is filled.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state <= ST_RUN;
      ptr   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (pop) begin
            ptr <= ptr_nxt[15:0];
            if (ptr_nxt[15:0] == CFLOW_LOGS_SIZE) state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (flush_ack) begin
            state <= ST_RUN;
            ptr   <= '0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Sticky overflow: a new drop in the same cycle as the flush keeps it set.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      ovf <= 1'b0;
    end else if (evt_valid && fifo_full) begin
      ovf <= 1'b1;
    end else if ((state == ST_FULL) && flush_ack) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cflog_ptr_ctrl.sv
// Directed and random stimulus against a queue-based model of the log controller.
module tb_cflog_ptr_ctrl;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic        evt_valid = 1'b0;
  logic [15:0] evt_src = '0;
  logic [15:0] evt_dest = '0;
  logic        evt_ready;
  logic        spec_hold = 1'b0;
  logic        flush_ack = 1'b0;
  logic [15:0] cflow_logs_ptr_din;
  logic [15:0] cflow_src;
  logic [15:0] cflow_dest;
  logic        cflow_hw_wen;
  logic        flush_req;
  logic        ovf;

  cflog_ptr_ctrl #(.CFLOW_LOGS_SIZE(16'(SIZE)), .FIFO_DEPTH(DEPTH)) dut (
    .mclk               (mclk),
    .puc_rst_n          (puc_rst_n),
    .evt_valid          (evt_valid),
    .evt_src            (evt_src),
    .evt_dest           (evt_dest),
    .evt_ready          (evt_ready),
    .spec_hold          (spec_hold),
    .flush_ack          (flush_ack),
    .cflow_logs_ptr_din (cflow_logs_ptr_din),
    .cflow_src          (cflow_src),
    .cflow_dest         (cflow_dest),
    .cflow_hw_wen       (cflow_hw_wen),
    .flush_req          (flush_req),
    .ovf                (ovf)
  );

  always #5 mclk = ~mclk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: pending events, log write position, full flag, overflow flag.
  logic [31:0] q[$];
  int          m_ptr  = 0;
  bit          m_full = 1'b0;
  bit          m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pop();
    return !m_full && (q.size() > 0) && !spec_hold && (m_ptr + 2 <= SIZE);
  endfunction

  task automatic model_clear();
    q.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_all();
    bit p;
    p = m_pop();
    chk("evt_ready", evt_ready, (q.size() < DEPTH));
    chk("cflow_hw_wen", cflow_hw_wen, p);
    chk("cflow_src", cflow_src, p ? q[0][31:16] : 16'h0);
    chk("cflow_dest", cflow_dest, p ? q[0][15:0] : 16'h0);
    chk("ptr_din", cflow_logs_ptr_din, p ? m_ptr + 2 : m_ptr);
    chk("flush_req", flush_req, m_full);
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic model_step();
    bit rdy;
    bit p;
    rdy = (q.size() < DEPTH);
    p   = m_pop();
    if (m_full && flush_ack) begin
      m_full = 1'b0;
      m_ptr  = 0;
      m_ovf  = 1'b0;
    end
    if (evt_valid && !rdy) m_ovf = 1'b1;
    if (p) begin
      void'(q.pop_front());
      m_ptr += 2;
      if (m_ptr == SIZE) m_full = 1'b1;
    end
    if (evt_valid && rdy) q.push_back({evt_src, evt_dest});
  endtask

  // One clock: check outputs mid-cycle, advance the model on the edge.
  task automatic cyc();
    @(negedge mclk);
    check_all();
    @(posedge mclk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] s, input logic [15:0] d);
    evt_valid = v;
    evt_src   = s;
    evt_dest  = d;
  endtask

  task automatic do_reset();
    puc_rst_n = 1'b0;
    drive(0, 16'h0, 16'h0);
    spec_hold = 1'b0;
    flush_ack = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge mclk);
    #1;
    puc_rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    cyc();

    // Single event lands in the next cycle at pointer 2
    drive(1, 16'hE010, 16'hE100);
    cyc();
    drive(0, 16'h0, 16'h0);
    #1;
    chk("first_wen", cflow_hw_wen, 1'b1);
    chk("first_src", cflow_src, 16'hE010);
    chk("first_dest", cflow_dest, 16'hE100);
    chk("first_ptr", cflow_logs_ptr_din, 16'd2);
    cyc();
    cyc();

    // Fill the log: four writes, fifth held until flush_ack
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'(16'h1000 + i), 16'(16'h2000 + i));
      cyc();
    end
    drive(0, 16'h0, 16'h0);
    #1;
    chk("full_flush_req", flush_req, 1'b1);
    chk("full_no_wen", cflow_hw_wen, 1'b0);
    cyc();
    cyc();
    flush_ack = 1'b1;
    cyc();
    flush_ack = 1'b0;
    #1;
    chk("fifth_wen", cflow_hw_wen, 1'b1);
    chk("fifth_src", cflow_src, 16'h1004);
    chk("fifth_ptr", cflow_logs_ptr_din, 16'd2);
    chk("fifth_flush_req", flush_req, 1'b0);
    cyc();
    cyc();

    // spec_hold stalls writes without losing order
    do_reset();
    spec_hold = 1'b1;
    drive(1, 16'hA001, 16'hB001);
    cyc();
    drive(1, 16'hA002, 16'hB002);
    cyc();
    drive(0, 16'h0, 16'h0);
    cyc();
    spec_hold = 1'b0;
    #1;
    chk("hold_first_src", cflow_src, 16'hA001);
    cyc();
    chk("hold_second_src", cflow_src, 16'hA002);
    chk("hold_second_ptr", cflow_logs_ptr_din, 16'd4);
    cyc();
    cyc();

    // Overflow with FIFO full; flush_ack in RUN must not clear it
    do_reset();
    spec_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 16'(16'h3000 + i), 16'(16'h4000 + i));
      cyc();
    end
    drive(0, 16'h0, 16'h0);
    #1;
    chk("ovf_ready_low", evt_ready, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    flush_ack = 1'b1;
    cyc();
    flush_ack = 1'b0;
    #1;
    chk("ovf_kept", ovf, 1'b1);
    spec_hold = 1'b0;
    for (int i = 0; i < 6; i++) cyc();

    // Asynchronous reset mid-stream discards queued events
    do_reset();
    spec_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'(16'h5000 + i), 16'(16'h6000 + i));
      cyc();
    end
    drive(0, 16'h0, 16'h0);
    #2;
    puc_rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("rst_wen", cflow_hw_wen, 1'b0);
    chk("rst_ready", evt_ready, 1'b1);
    @(posedge mclk);
    #1;
    puc_rst_n = 1'b1;
    spec_hold = 1'b0;
    for (int i = 0; i < 3; i++) cyc();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 3) != 0, 16'($urandom), 16'($urandom));
      spec_hold = (($urandom % 4) == 0);
      flush_ack = (($urandom % 5) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cflog_ptr_ctrl.md
CFLOG_PTR_CTRL -- requirements
Module: cflog_ptr_ctrl

Interface
REQ-001 SHALL have parameter CFLOW_LOGS_SIZE, default 16'h0100, cflog capacity in 16-bit words; must be even.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event buffer entries (power of two).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 mclk  in  1  main system clock.
REQ-005 puc_rst_n  in  1  async active-low reset.
REQ-006 evt_valid  in  1  control-flow event offered.
REQ-007 evt_src  in  16  jump-from address.
REQ-008 evt_dest  in  16  jump-to address.
REQ-009 evt_ready  out  1  event accepted when evt_valid&evt_ready.
REQ-010 spec_hold  in  1  Spec-CFA detect_active; cflog write port busy.
REQ-011 flush_ack  in  1  one-cycle pulse: log consumed, restart at 0.
REQ-012 cflow_logs_ptr_din  out  16  post-increment word pointer to cflogmem.
REQ-013 cflow_src  out  16  entry word 0 to cflogmem.
REQ-014 cflow_dest  out  16  entry word 1 to cflogmem.
REQ-015 cflow_hw_wen  out  1  single-cycle write strobe to cflogmem.
REQ-016 flush_req  out  1  log full, level until flush_ack.
REQ-017 ovf  out  1  sticky: event offered while evt_ready low.

Function
REQ-018 Accepted events SHALL enter a FIFO_DEPTH-entry FIFO of {src,dest}; evt_ready = ~fifo_full (registered-state derived, no dependency on evt_valid).
REQ-019 FSM states SHALL be RUN and FULL; reset state RUN.
REQ-020 In RUN, a pop SHALL occur when fifo non-empty & ~spec_hold & ptr+2 <= CFLOW_LOGS_SIZE.
REQ-021 On pop, same cycle: cflow_hw_wen=1, cflow_src/dest = FIFO head, cflow_logs_ptr_din = ptr+2; ptr register SHALL become ptr+2 (downstream writes words ptr, ptr+1).
REQ-022 When no pop, cflow_hw_wen=0, cflow_src/dest=0, cflow_logs_ptr_din = ptr.
REQ-023 Minimum latency SHALL be 1 cycle: event accepted in cycle N writes in cycle N+1; throughput one entry per cycle.
REQ-024 Simultaneous push and pop SHALL be supported, including when FIFO full (ready low blocks push regardless).
REQ-025 RUN->FULL SHALL occur in the cycle after ptr reaches CFLOW_LOGS_SIZE; flush_req=1 in FULL only.
REQ-026 In FULL, no pops; FIFO SHALL keep accepting until full.
REQ-027 FULL->RUN on flush_ack: ptr:=0, ovf:=0, FIFO contents retained; first pop no earlier than next cycle.
REQ-028 flush_ack in RUN SHALL be ignored.
REQ-029 spec_hold high SHALL stall pops with no loss; FIFO and ptr unchanged except pushes.
REQ-030 ovf SHALL set on evt_valid & ~evt_ready and hold until flush_ack or reset.
REQ-031 Pointer arithmetic SHALL be 16-bit unsigned; ptr never exceeds CFLOW_LOGS_SIZE, never wraps.

Reset
REQ-032 On puc_rst_n low (async), SHALL force: state RUN, ptr 0, FIFO empty, ovf 0, cflow_hw_wen 0, flush_req 0, cflow_src/dest 0, cflow_logs_ptr_din 0, evt_ready 1 (after release).
REQ-033 Reset mid-write or in FULL SHALL discard pending events; no wen in the release cycle.

Structure
REQ-034 FSM state encoding and the entry-size constant (2 words) SHALL reside in shared package cflog_pkg.
REQ-035 FIFO SHALL be sub-module cflog_evt_fifo (parameter DEPTH, 32-bit data, push/pop/full/empty).

Verification
REQ-036 Reset, one event src=16'hE010,dest=16'hE100 -> next cycle wen=1, src/dest match, ptr_din=2.
REQ-037 SIZE=8, 5 back-to-back events -> 4 writes ptr_din 2,4,6,8; flush_req=1; fifth held; flush_ack -> fifth written with ptr_din=2.
REQ-038 spec_hold high 3 cycles with 2 events queued -> no wen during hold; both written on consecutive cycles after release, order preserved.
REQ-039 FIFO_DEPTH=4, spec_hold high, 6 valid events -> evt_ready low after 4, ovf=1; flush_ack in RUN leaves ovf=1.
REQ-040 Assert puc_rst_n low mid-stream with 3 queued -> all outputs reset values immediately; no wen after release until new event.
